// File: rtl/modexp_stream_ctrl.sv
// rtl/modexp_stream_ctrl.sv - word-serial operand load / result unload sequencer for the modexp core
// Holds NUM_OPERANDS operand slots and one result buffer, sequenced by a five-state FSM.
module modexp_stream_ctrl #(
  parameter  int DATA_WIDTH   = 128,
  parameter  int NUM_WORDS    = 32,
  parameter  int NUM_OPERANDS = 3,
  localparam int OPW          = (NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1,
  localparam int IW           = $clog2(NUM_WORDS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_input,
  input  logic [OPW-1:0]          op_sel,
  input  logic [DATA_WIDTH-1:0]   inp,
  input  logic                    inp_valid,
  output logic                    in_ready,
  output logic [NUM_OPERANDS-1:0] loaded_mask,
  input  logic                    start_compute,
  output logic                    core_start,
  input  logic [OPW-1:0]          core_rd_op,
  input  logic [IW-1:0]           core_rd_idx,
  output logic [DATA_WIDTH-1:0]   core_rd_data,
  input  logic                    core_wr_en,
  input  logic [IW-1:0]           core_wr_idx,
  input  logic [DATA_WIDTH-1:0]   core_wr_data,
  input  logic                    core_done,
  input  logic                    get_result,
  output logic [DATA_WIDTH-1:0]   outp,
  output logic                    outp_valid,
  input  logic                    out_ready,
  output logic                    outp_last,
  output logic [2:0]              state,
  output logic                    err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    COMPUTE = 3'd2,
    RESULT  = 3'd3,
    UNLOAD  = 3'd4
  } state_t;

  state_t stateQ, stateNext;

  logic [DATA_WIDTH-1:0]   mem [NUM_OPERANDS][NUM_WORDS];
  logic [DATA_WIDTH-1:0]   res [NUM_WORDS];
  logic [OPW-1:0]          curOp;
  logic [IW-1:0]           wordCnt;
  logic [IW-1:0]           outIdx;
  logic [NUM_OPERANDS-1:0] loadedMask;
  logic                    errQ;
  logic [DATA_WIDTH-1:0]   rdData;

  logic selOk, loadStart, badSel, loadWe, computeGo, computeErr, unloadGo, outAccept;
  logic lastWord, lastOut;

  assign selOk    = int'(op_sel) < NUM_OPERANDS;
  assign lastWord = (wordCnt == IW'(NUM_WORDS - 1));
  assign lastOut  = (outIdx == IW'(NUM_WORDS - 1));

  always_comb begin
    stateNext  = stateQ;
    loadStart  = 1'b0;
    badSel     = 1'b0;
    loadWe     = 1'b0;
    computeGo  = 1'b0;
    computeErr = 1'b0;
    unloadGo   = 1'b0;
    outAccept  = 1'b0;
    in_ready   = 1'b0;
    outp_valid = 1'b0;
    outp_last  = 1'b0;
    case (stateQ)
      IDLE: begin
        // start_input has priority; a same-cycle start_compute is dropped
        if (start_input) begin
          if (selOk) begin
            loadStart = 1'b1;
            stateNext = LOAD;
          end else begin
            badSel = 1'b1;
          end
        end else if (start_compute) begin
          if (&loadedMask) begin
            computeGo = 1'b1;
            stateNext = COMPUTE;
          end else begin
            computeErr = 1'b1;
          end
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        if (start_input && selOk) begin
          loadStart = 1'b1;
        end else begin
          badSel = start_input;
          if (inp_valid) begin
            loadWe = 1'b1;
            if (lastWord) stateNext = IDLE;
          end
        end
      end
      COMPUTE: begin
        if (core_done) stateNext = RESULT;
      end
      RESULT: begin
        if (get_result) begin
          unloadGo  = 1'b1;
          stateNext = UNLOAD;
        end
      end
      UNLOAD: begin
        outp_valid = 1'b1;
        outp_last  = lastOut;
        if (out_ready) begin
          outAccept = 1'b1;
          if (lastOut) stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
    core_start = computeGo;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stateQ     <= IDLE;
      curOp      <= '0;
      wordCnt    <= '0;
      outIdx     <= '0;
      loadedMask <= '0;
      errQ       <= 1'b0;
      rdData     <= '0;
    end else begin
      stateQ <= stateNext;
      if (badSel || computeErr) errQ <= 1'b1;
      if (loadStart) begin
        curOp               <= op_sel;
        wordCnt             <= '0;
        loadedMask[op_sel]  <= 1'b0;
      end else if (loadWe) begin
        wordCnt <= wordCnt + IW'(1);
        if (lastWord) loadedMask[curOp] <= 1'b1;
      end
      if (unloadGo) outIdx <= '0;
      else if (outAccept) outIdx <= outIdx + IW'(1);
      // unused slot codes read as zero rather than out-of-range storage
      if (int'(core_rd_op) < NUM_OPERANDS) rdData <= mem[core_rd_op][core_rd_idx];
      else rdData <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (loadWe) mem[curOp][wordCnt] <= inp;
    if (stateQ == COMPUTE && core_wr_en) res[core_wr_idx] <= core_wr_data;
  end

  assign outp         = outp_valid ? res[outIdx] : '0;
  assign loaded_mask  = loadedMask;
  assign err          = errQ;
  assign state        = stateQ;
  assign core_rd_data = rdData;

endmodule
